// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm-clock front-panel sequencer (set modes, auto-repeat, ring/snooze/timeout FSM)
module alarm_ctrl #(
    parameter int RING_SEC        = 60,
    parameter int SNOOZE_SEC      = 300,
    parameter int SNOOZE_MAX      = 3,
    parameter int SET_TIMEOUT_SEC = 10,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_snooze,
    input  logic       on,
    input  logic       alarm_hit,
    output logic       addhr,
    output logic       addmin,
    output logic [1:0] set_mode,
    output logic       buzzer,
    output logic       snoozing
);
    typedef enum logic [2:0] {IDLE, SET_HR, SET_MIN, RINGING, SNOOZE} state_t;

    localparam logic [CNT_W-1:0] RING_C = CNT_W'(RING_SEC);
    localparam logic [CNT_W-1:0] SNZ_C  = CNT_W'(SNOOZE_SEC);
    localparam logic [CNT_W-1:0] SMAX_C = CNT_W'(SNOOZE_MAX);
    localparam logic [CNT_W-1:0] TO_C   = CNT_W'(SET_TIMEOUT_SEC);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, snz_q, snz_d;
    logic [1:0]       hold_q, hold_d;
    logic             addhr_q, addhr_d, addmin_q, addmin_d;
    logic             mode_prev_q, inc_prev_q, snz_prev_q, hit_prev_q;
    logic             mode_p, inc_p, snz_p, hit_p, in_set, rep;

    // Next-state, shared seconds counter, snooze count, held-tick count and increment pulses
    always_comb begin
        mode_p   = btn_mode & ~mode_prev_q;
        inc_p    = btn_inc & ~inc_prev_q;
        snz_p    = btn_snooze & ~snz_prev_q;
        hit_p    = alarm_hit & ~hit_prev_q;
        in_set   = (state_q == SET_HR) || (state_q == SET_MIN);
        cnt_inc  = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
        rep      = tick_1hz & btn_inc & (hold_q >= 2'd2);
        state_d  = state_q;
        cnt_d    = cnt_q;
        snz_d    = snz_q;
        hold_d   = (in_set & btn_inc) ? (tick_1hz & ~&hold_q ? hold_q + 2'd1 : hold_q) : 2'd0;
        addhr_d  = 1'b0;
        addmin_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (mode_p) state_d = SET_HR;
                else if (hit_p & on) state_d = RINGING;
            end
            SET_HR, SET_MIN: begin
                if (mode_p) begin
                    state_d = (state_q == SET_HR) ? SET_MIN : IDLE;
                    cnt_d   = '0;
                end else begin
                    addhr_d  = (state_q == SET_HR) & (inc_p | rep);
                    addmin_d = (state_q == SET_MIN) & (inc_p | rep);
                    if (inc_p | snz_p | btn_inc) cnt_d = '0;
                    else if (tick_1hz) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= TO_C) state_d = IDLE;
                    end
                end
            end
            RINGING: begin
                if (!on || mode_p) state_d = IDLE;
                else if (snz_p && snz_q < SMAX_C) begin
                    state_d = SNOOZE;
                    snz_d   = snz_q + CNT_W'(1);
                    cnt_d   = '0;
                end else if (tick_1hz) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= RING_C) state_d = IDLE;
                end
            end
            SNOOZE: begin
                if (!on || mode_p) state_d = IDLE;
                else if (tick_1hz) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= SNZ_C) begin
                        state_d = RINGING;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) begin
            cnt_d = '0;
            snz_d = '0;
        end
    end

    // State, counters, pulse and edge-detect registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            snz_q       <= '0;
            hold_q      <= '0;
            addhr_q     <= 1'b0;
            addmin_q    <= 1'b0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            snz_prev_q  <= 1'b0;
            hit_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snz_q       <= snz_d;
            hold_q      <= hold_d;
            addhr_q     <= addhr_d;
            addmin_q    <= addmin_d;
            mode_prev_q <= btn_mode;
            inc_prev_q  <= btn_inc;
            snz_prev_q  <= btn_snooze;
            hit_prev_q  <= alarm_hit;
        end
    end

    assign addhr    = addhr_q;
    assign addmin   = addmin_q;
    assign buzzer   = state_q == RINGING;
    assign snoozing = state_q == SNOOZE;
    assign set_mode = (state_q == SET_HR)  ? 2'd1 :
                      (state_q == SET_MIN) ? 2'd2 :
                      (state_q == RINGING || state_q == SNOOZE) ? 2'd3 : 2'd0;
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed scenario bench for alarm_ctrl with small timing parameters
module tb_alarm_ctrl;
    logic clk = 1'b0, rst = 1'b1, tick_1hz = 1'b0;
    logic btn_mode = 1'b0, btn_inc = 1'b0, btn_snooze = 1'b0, on = 1'b0, alarm_hit = 1'b0;
    logic addhr, addmin, buzzer, snoozing;
    logic [1:0] set_mode;
    int checks = 0, failures = 0;
    int nhr = 0, nmin = 0, nlong = 0;
    logic prev_hr = 1'b0, prev_min = 1'b0;

    alarm_ctrl #(.RING_SEC(4), .SNOOZE_SEC(2), .SNOOZE_MAX(2), .SET_TIMEOUT_SEC(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_snooze(btn_snooze), .on(on), .alarm_hit(alarm_hit), .addhr(addhr), .addmin(addmin),
        .set_mode(set_mode), .buzzer(buzzer), .snoozing(snoozing)
    );

    always #5 clk = ~clk;

    // advance n cycles, sampling 1 time unit after each rising edge and tallying pulses
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (addhr) nhr++;
            if (addmin) nmin++;
            if ((addhr && prev_hr) || (addmin && prev_min)) nlong++;
            prev_hr = addhr;
            prev_min = addmin;
        end
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
        cyc(1);
    endtask

    task automatic clear_counts();
        nhr = 0;
        nmin = 0;
        nlong = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(2);
        checks++; if (set_mode !== 2'd0) begin failures++; $display("FAIL reset_set_mode got=%0d exp=0", set_mode); end
        checks++; if ({addhr, addmin, buzzer, snoozing} !== 4'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=0000", {addhr, addmin, buzzer, snoozing}); end
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_hour_set();
        btn_mode = 1'b1; cyc(1); btn_mode = 1'b0; cyc(1);
        checks++; if (set_mode !== 2'd1) begin failures++; $display("FAIL hr_enter set_mode got=%0d exp=1", set_mode); end
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            btn_inc = 1'b1; cyc(1); btn_inc = 1'b0; cyc(3);
        end
        checks++; if (nhr !== 3) begin failures++; $display("FAIL hr_pulses got=%0d exp=3", nhr); end
        checks++; if (nmin !== 0) begin failures++; $display("FAIL hr_no_min got=%0d exp=0", nmin); end
        checks++; if (nlong !== 0) begin failures++; $display("FAIL hr_pulse_width long=%0d exp=0", nlong); end
        checks++; if (set_mode !== 2'd1) begin failures++; $display("FAIL hr_stay set_mode got=%0d exp=1", set_mode); end
    endtask

    task automatic test_autorepeat_timeout();
        btn_mode = 1'b1; cyc(1); btn_mode = 1'b0; cyc(1);
        checks++; if (set_mode !== 2'd2) begin failures++; $display("FAIL min_enter set_mode got=%0d exp=2", set_mode); end
        clear_counts();
        btn_inc = 1'b1;
        cyc(1);
        for (int i = 0; i < 6; i++) tick();
        checks++; if (nmin !== 5) begin failures++; $display("FAIL min_repeat got=%0d exp=5", nmin); end
        checks++; if (nhr !== 0 || nlong !== 0) begin failures++; $display("FAIL min_repeat_clean hr=%0d long=%0d exp=0,0", nhr, nlong); end
        checks++; if (set_mode !== 2'd2) begin failures++; $display("FAIL hold_is_activity set_mode got=%0d exp=2", set_mode); end
        btn_inc = 1'b0;
        cyc(1);
        tick(); tick();
        checks++; if (set_mode !== 2'd2) begin failures++; $display("FAIL timeout_early set_mode got=%0d exp=2", set_mode); end
        tick();
        checks++; if (set_mode !== 2'd0) begin failures++; $display("FAIL timeout set_mode got=%0d exp=0", set_mode); end
    endtask

    task automatic test_ring_timeout();
        on = 1'b1;
        alarm_hit = 1'b1;
        tick_1hz = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
        checks++; if (buzzer !== 1'b1 || set_mode !== 2'd3) begin failures++; $display("FAIL ring_start buzzer=%b set_mode=%0d exp=1,3", buzzer, set_mode); end
        cyc(1);
        tick(); tick(); tick();
        checks++; if (buzzer !== 1'b1) begin failures++; $display("FAIL ring_third_tick buzzer=%b exp=1", buzzer); end
        tick();
        checks++; if (buzzer !== 1'b0 || set_mode !== 2'd0) begin failures++; $display("FAIL ring_timeout buzzer=%b set_mode=%0d exp=0,0", buzzer, set_mode); end
        cyc(3);
        checks++; if (buzzer !== 1'b0) begin failures++; $display("FAIL ring_no_retrigger buzzer=%b exp=0", buzzer); end
        alarm_hit = 1'b0;
        cyc(1);
    endtask

    task automatic test_snooze_limit();
        alarm_hit = 1'b1; cyc(1);
        checks++; if (buzzer !== 1'b1) begin failures++; $display("FAIL snz_ring buzzer=%b exp=1", buzzer); end
        for (int k = 0; k < 2; k++) begin
            btn_snooze = 1'b1; cyc(1); btn_snooze = 1'b0;
            checks++; if (snoozing !== 1'b1 || buzzer !== 1'b0) begin failures++; $display("FAIL snz_enter%0d snoozing=%b buzzer=%b exp=1,0", k, snoozing, buzzer); end
            cyc(1);
            tick();
            checks++; if (snoozing !== 1'b1) begin failures++; $display("FAIL snz_hold%0d snoozing=%b exp=1", k, snoozing); end
            tick();
            checks++; if (buzzer !== 1'b1) begin failures++; $display("FAIL snz_rering%0d buzzer=%b exp=1", k, buzzer); end
        end
        btn_snooze = 1'b1; cyc(1); btn_snooze = 1'b0; cyc(1);
        checks++; if (buzzer !== 1'b1 || snoozing !== 1'b0) begin failures++; $display("FAIL snz_limit buzzer=%b snoozing=%b exp=1,0", buzzer, snoozing); end
        btn_mode = 1'b1; cyc(1); btn_mode = 1'b0;
        checks++; if (set_mode !== 2'd0) begin failures++; $display("FAIL ring_mode_exit set_mode=%0d exp=0", set_mode); end
        alarm_hit = 1'b0; cyc(1);
    endtask

    task automatic test_priority();
        alarm_hit = 1'b1; cyc(1);
        on = 1'b0; btn_snooze = 1'b1; cyc(1);
        checks++; if (set_mode !== 2'd0 || snoozing !== 1'b0) begin failures++; $display("FAIL prio_off set_mode=%0d snoozing=%b exp=0,0", set_mode, snoozing); end
        btn_snooze = 1'b0; on = 1'b1; alarm_hit = 1'b0; cyc(1);
        checks++; if (snoozing !== 1'b0) begin failures++; $display("FAIL prio_off_after snoozing=%b exp=0", snoozing); end
        alarm_hit = 1'b1; cyc(1);
        btn_snooze = 1'b1; cyc(1); btn_snooze = 1'b0;
        checks++; if (snoozing !== 1'b1) begin failures++; $display("FAIL snz_count_cleared snoozing=%b exp=1", snoozing); end
        btn_mode = 1'b1; cyc(1); btn_mode = 1'b0; alarm_hit = 1'b0; cyc(1);
        checks++; if (set_mode !== 2'd0) begin failures++; $display("FAIL snz_mode_exit set_mode=%0d exp=0", set_mode); end
        btn_mode = 1'b1; cyc(1); btn_mode = 1'b0; cyc(1);
        clear_counts();
        btn_mode = 1'b1; btn_inc = 1'b1; cyc(1);
        checks++; if (set_mode !== 2'd2) begin failures++; $display("FAIL prio_mode_inc set_mode=%0d exp=2", set_mode); end
        btn_mode = 1'b0; btn_inc = 1'b0; cyc(2);
        checks++; if (nhr !== 0 || nmin !== 0) begin failures++; $display("FAIL prio_no_pulse hr=%0d min=%0d exp=0,0", nhr, nmin); end
        btn_mode = 1'b1; cyc(1); btn_mode = 1'b0; cyc(1);
    endtask

    task automatic test_async_reset();
        alarm_hit = 1'b1; cyc(1);
        checks++; if (buzzer !== 1'b1) begin failures++; $display("FAIL ar_ring buzzer=%b exp=1", buzzer); end
        #2 rst = 1'b1;
        #1;
        checks++; if (buzzer !== 1'b0 || set_mode !== 2'd0) begin failures++; $display("FAIL ar_async buzzer=%b set_mode=%0d exp=0,0", buzzer, set_mode); end
        btn_mode = 1'b1; alarm_hit = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        checks++; if (set_mode !== 2'd1) begin failures++; $display("FAIL ar_held_press set_mode=%0d exp=1", set_mode); end
        cyc(3);
        checks++; if (set_mode !== 2'd1) begin failures++; $display("FAIL ar_single_press set_mode=%0d exp=1", set_mode); end
        btn_mode = 1'b0; cyc(1);
    endtask

    initial begin
        test_reset();
        test_hour_set();
        test_autorepeat_timeout();
        test_ring_timeout();
        test_snooze_limit();
        test_priority();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Front-panel sequencer for the alarm-clock subsystem. It turns three synchronized push-buttons and a once-per-second strobe into single-cycle `addhr`/`addmin` increment pulses for the alarm-time register. It also runs the ringing, snooze and timeout state machine behind the buzzer. It sits between the button synchronizers and the alarm register/comparator, which supplies the `alarm_hit` level.

## Interface
- RING_SEC, 60, seconds of ringing before automatic silence
- SNOOZE_SEC, 300, seconds between snooze press and re-ring
- SNOOZE_MAX, 3, snoozes allowed per alarm event
- SET_TIMEOUT_SEC, 10, seconds of button inactivity before a set mode exits
- CNT_W, 16, width of the seconds counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick_1hz  in  1  one-cycle strobe per second
- btn_mode  in  1  mode button, already synchronized level
- btn_inc  in  1  increment button, already synchronized level
- btn_snooze  in  1  snooze button, already synchronized level
- on  in  1  alarm enable switch
- alarm_hit  in  1  level, high while current time equals alarm time
- addhr  out  1  one-cycle pulse: alarm hour +1
- addmin  out  1  one-cycle pulse: alarm minute +1
- set_mode  out  2  0 = idle, 1 = setting hour, 2 = setting minute, 3 = alarm active (ringing or snoozing)
- buzzer  out  1  high while ringing
- snoozing  out  1  high while in SNOOZE

## Operation
- Edge detect: each button has a previous-sample register, reset to 0. A "press" is the current sample at 1 with the previous sample at 0. A button held through reset release counts as one press.
- `alarm_hit` also has an edge detect. Only its rising edge triggers ringing.
- FSM states:
  - IDLE: mode press → SET_HR. Rising `alarm_hit` with `on`=1 → RINGING, snooze count cleared.
  - SET_HR: inc press → `addhr` pulse. Mode press → SET_MIN.
  - SET_MIN: inc press → `addmin` pulse. Mode press → IDLE.
  - RINGING: `buzzer`=1. Snooze press with snooze count < SNOOZE_MAX → SNOOZE, count +1. Snooze press at SNOOZE_MAX is ignored. Mode press → IDLE. RING_SEC ticks elapsed → IDLE.
  - SNOOZE: `snoozing`=1. SNOOZE_SEC ticks elapsed → RINGING, with the seconds counter cleared. Mode press → IDLE.
- Auto-repeat in SET_HR/SET_MIN: while `btn_inc` is held, held ticks are counted. On every tick once the held count is ≥ 2, one more pulse is issued. Release clears the held count.
- Set-mode inactivity: the seconds counter clears on any button press and increments per tick. At SET_TIMEOUT_SEC → IDLE. Holding `btn_inc` counts as activity.
- `on`=0 in RINGING or SNOOZE → IDLE next edge. This has highest priority.
- Priority within a cycle: `on`=0, then mode press, then snooze press, then inc press, then timers. A mode press plus an inc press in the same cycle produces no increment pulse.
- `alarm_hit` edges are ignored in every state except IDLE.
- Arithmetic: the seconds counter is CNT_W bits and saturates, never wraps. Comparisons use ≥.
- The snooze count is cleared on entry to IDLE.

## Timing
- Reset, asynchronous: state IDLE; all counters 0; edge registers 0; `addhr`=`addmin`=`buzzer`=`snoozing`=0; `set_mode`=0.
- Press sampled at edge k → `addhr`/`addmin` high for exactly the cycle after edge k. Never longer than one cycle.
- Outputs are registered, decoded from the state register. `buzzer`/`set_mode` change the cycle after the triggering edge.
- Ring timeout: the state leaves RINGING at the edge that samples the RING_SEC-th tick after entry. The tick arriving in the entry cycle is not counted.
- Reset asserted mid-ring or mid-pulse: `buzzer` and pulses drop immediately, without waiting for a clock edge.

## Test plan
- Hour set: reset, mode press, 3 inc presses spaced 4 cycles apart → exactly 3 one-cycle `addhr` pulses, no `addmin`, `set_mode`=1.
- Auto-repeat and timeout: SET_MIN, `btn_inc` held for 6 ticks → 1 press pulse + 4 repeat pulses (5 `addmin` total). Then release and wait SET_TIMEOUT_SEC=3 ticks → `set_mode`=0.
- Ring timeout: `on`=1, RING_SEC=4, `alarm_hit` rises → `buzzer`=1 next cycle, 0 after the 4th tick. `alarm_hit` still high → no retrigger.
- Snooze limit: SNOOZE_SEC=2, SNOOZE_MAX=2. Ring, snooze, wait 2 ticks, re-ring, snooze, re-ring, third snooze press → `buzzer` stays 1.
- Priority: in RINGING, drive `on`=0 and a snooze press in the same cycle → IDLE, `snoozing` never 1. In SET_HR, mode and inc presses together → SET_MIN, no `addhr`.
- Async reset: assert `rst` between edges while `buzzer`=1 → `buzzer`=0 before the next `clk` edge. Release with `btn_mode` held → one press, `set_mode`=1.
